// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register-address type and helpers for the writeback register file
package wb_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    typedef logic [4:0] reg_addr_t;
    localparam reg_addr_t REG_ZERO = 5'd31;
    function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NREGS; i++) popcount += 6'(v[i]);
    endfunction
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: pending-load vector, load-use stall and in-flight load count
module load_scoreboard
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  reg_addr_t  wr_addr,
    input  reg_addr_t  rd_a_addr,
    input  reg_addr_t  rd_b_addr,
    input  logic       issue_valid,
    input  logic       issue_load,
    input  reg_addr_t  issue_dst,
    input  logic       issue_use_a,
    input  logic       issue_use_b,
    output logic       load_stall,
    output logic [5:0] pending_cnt
);
    logic [NREGS-1:0] pending, pending_nxt;
    logic busy_a, busy_b;
    // a completing writeback releases its register in the same cycle through the bypass
    always_comb begin
        busy_a = pending[rd_a_addr] && !(wr_en && wr_addr == rd_a_addr);
        busy_b = pending[rd_b_addr] && !(wr_en && wr_addr == rd_b_addr);
        load_stall = issue_valid && ((issue_use_a && busy_a) || (issue_use_b && busy_b));
        pending_nxt = pending;
        if (wr_en && wr_addr != REG_ZERO) pending_nxt[wr_addr] = 1'b0;
        if (issue_valid && issue_load && !load_stall && issue_dst != REG_ZERO) pending_nxt[issue_dst] = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= popcount(pending_nxt);
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file with same-cycle bypass and load-use scoreboard
module wb_regfile #(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int NREGS = wb_pkg::NREGS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  wb_pkg::reg_addr_t  wr_addr,
    input  logic [XLEN-1:0]    wr_data,
    input  wb_pkg::reg_addr_t  rd_a_addr,
    input  wb_pkg::reg_addr_t  rd_b_addr,
    output logic [XLEN-1:0]    rd_a_data,
    output logic [XLEN-1:0]    rd_b_data,
    input  logic               issue_valid,
    input  logic               issue_load,
    input  wb_pkg::reg_addr_t  issue_dst,
    input  logic               issue_use_a,
    input  logic               issue_use_b,
    output logic               load_stall,
    output logic [5:0]         pending_cnt
);
    import wb_pkg::*;
    logic [XLEN-1:0] regs [NREGS-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != REG_ZERO) begin
            regs[wr_addr] <= wr_data;
        end
    end
    assign rd_a_data = (rd_a_addr == REG_ZERO) ? '0 : (wr_en && wr_addr == rd_a_addr) ? wr_data : regs[rd_a_addr];
    assign rd_b_data = (rd_b_addr == REG_ZERO) ? '0 : (wr_en && wr_addr == rd_b_addr) ? wr_data : regs[rd_b_addr];
    load_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .issue_valid (issue_valid),
        .issue_load  (issue_load),
        .issue_dst   (issue_dst),
        .issue_use_a (issue_use_a),
        .issue_use_b (issue_use_b),
        .load_stall  (load_stall),
        .pending_cnt (pending_cnt)
    );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors with hand-computed expectations for wb_regfile
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_a_addr, rd_b_addr;
    logic [63:0] rd_a_data, rd_b_data;
    logic        issue_valid, issue_load, issue_use_a, issue_use_b;
    logic [4:0]  issue_dst;
    logic        load_stall;
    logic [5:0]  pending_cnt;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .rd_a_data   (rd_a_data),
        .rd_b_data   (rd_b_data),
        .issue_valid (issue_valid),
        .issue_load  (issue_load),
        .issue_dst   (issue_dst),
        .issue_use_a (issue_use_a),
        .issue_use_b (issue_use_b),
        .load_stall  (load_stall),
        .pending_cnt (pending_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        issue_valid = 0; issue_load = 0; issue_dst = 0; issue_use_a = 0; issue_use_b = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    task automatic issue(input logic ld, input logic [4:0] dst, input logic ua, input logic ub);
        issue_valid = 1; issue_load = ld; issue_dst = dst; issue_use_a = ua; issue_use_b = ub;
    endtask

    initial begin
        rst_n = 0; idle(); rd_a_addr = 0; rd_b_addr = 0;
        #12;
        chk("rst_rd_a", rd_a_data, 0);
        chk("rst_stall", load_stall, 0);
        chk("rst_cnt", pending_cnt, 0);
        #5 rst_n = 1;
        tick();
        // bypass then storage
        wr(3, 64'h1234); rd_a_addr = 3; rd_b_addr = 3; #1;
        chk("bypass_a", rd_a_data, 64'h1234);
        chk("bypass_b", rd_b_data, 64'h1234);
        tick(); idle(); #1;
        chk("stored_a", rd_a_data, 64'h1234);
        // R31 never written, never tracked
        wr(31, 64'hFFFF); rd_a_addr = 31; rd_b_addr = 31; #1;
        chk("r31_byp_a", rd_a_data, 0);
        chk("r31_byp_b", rd_b_data, 0);
        tick(); idle(); #1;
        chk("r31_a", rd_a_data, 0);
        chk("r31_b", rd_b_data, 0);
        issue(1, 31, 0, 0); #1;
        chk("r31_ld_stall", load_stall, 0);
        tick(); idle(); #1;
        chk("r31_ld_cnt", pending_cnt, 0);
        // load-use on R7
        issue(1, 7, 0, 0); #1;
        chk("ld7_stall", load_stall, 0);
        tick();
        chk("ld7_cnt", pending_cnt, 1);
        issue(0, 0, 1, 0); rd_a_addr = 7; #1;
        chk("use7_stall0", load_stall, 1);
        tick();
        chk("use7_stall1", load_stall, 1);
        tick();
        chk("use7_stall2", load_stall, 1);
        wr(7, 64'h42); #1;
        chk("use7_release", load_stall, 0);
        chk("use7_data", rd_a_data, 64'h42);
        tick(); idle(); #1;
        chk("use7_cnt", pending_cnt, 0);
        chk("use7_stored", rd_a_data, 64'h42);
        // set/clear collision on R9
        issue(1, 9, 0, 0); tick();
        chk("ld9_cnt", pending_cnt, 1);
        wr(9, 64'h99); issue(1, 9, 0, 0); #1;
        chk("coll_stall", load_stall, 0);
        tick(); idle(); #1;
        chk("coll_cnt", pending_cnt, 1);
        issue(0, 0, 0, 1); rd_b_addr = 9; #1;
        chk("coll_still_busy", load_stall, 1);
        idle(); wr(9, 64'h9A); tick(); idle(); #1;
        chk("coll_clear_cnt", pending_cnt, 0);
        chk("coll_data", rd_b_data, 64'h9A);
        // stalled load must not set its destination
        issue(1, 2, 0, 0); tick();
        chk("ld2_cnt", pending_cnt, 1);
        issue(1, 4, 1, 0); rd_a_addr = 2; #1;
        chk("nset_stall", load_stall, 1);
        tick();
        chk("nset_cnt", pending_cnt, 1);
        issue(0, 0, 1, 0); rd_a_addr = 4; #1;
        chk("nset_r4_free", load_stall, 0);
        issue(0, 0, 0, 0); #1;
        rd_a_addr = 2; issue(0, 0, 0, 0); #1;
        chk("unused_src_no_stall", load_stall, 0);
        idle(); wr(2, 64'h2); tick(); idle(); #1;
        chk("ld2_clear_cnt", pending_cnt, 0);
        // mid-run reset discards state and blocks writes
        wr(5, 64'hDEAD); issue(1, 6, 0, 0); tick(); idle(); rd_a_addr = 5; #1;
        chk("r5_written", rd_a_data, 64'hDEAD);
        chk("ld6_cnt", pending_cnt, 1);
        rst_n = 0; wr(6, 64'hBEEF); #1;
        chk("mid_rst_cnt", pending_cnt, 0);
        tick(); rst_n = 1; idle(); #1;
        chk("mid_rst_r5", rd_a_data, 0);
        rd_a_addr = 6; #1;
        chk("mid_rst_r6", rd_a_data, 0);
        issue(0, 0, 1, 0); #1;
        chk("mid_rst_stall", load_stall, 0);
        tick(); idle(); #1;
        chk("mid_rst_cnt_after", pending_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
